aud_codec_i2s_model: RTL and testbench

- Synthesizable model of the audio codec's digital-audio end, acting as the I2S bus master (codec master mode).
- Generates BCLK and the ADC/DAC LR clocks, serializes supplied ADC samples onto ADCDAT, and deserializes the DACDAT stream driven by the design.
- Connects directly to the design's i_AUD_BCLK, i_AUD_ADCLRCK, i_AUD_DACLRCK, i_AUD_ADCDAT and o_AUD_DACDAT pins for closed-loop recorder/player simulation and on-chip loopback.

---
 rtl/aud_codec_i2s_model.sv | 140 ++++++++++++++
 tb/tb_aud_codec_i2s_model.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/aud_codec_i2s_model.sv
// aud_codec_i2s_model: I2S bus-master codec model generating BCLK/LRCK,
// serializing ADC samples and capturing the DAC stream from the design.
module aud_codec_i2s_model #(
    parameter int BCLK_DIV  = 2,
    parameter int SLOT_BITS = 32,
    parameter int DATA_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_adc_left,
    input  logic [DATA_W-1:0] i_adc_right,
    output logic              o_adc_req,
    output logic              o_AUD_BCLK,
    output logic              o_AUD_ADCLRCK,
    output logic              o_AUD_DACLRCK,
    output logic              o_AUD_ADCDAT,
    input  logic              i_AUD_DACDAT,
    output logic [DATA_W-1:0] o_dac_left,
    output logic [DATA_W-1:0] o_dac_right,
    output logic              o_dac_valid
);
    localparam int CW  = $clog2(SLOT_BITS);
    localparam int DVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0]  DW   = CW'(DATA_W);
    localparam logic [DVW-1:0] DMAX = DVW'(BCLK_DIV - 1);

    if (SLOT_BITS < DATA_W + 1 || BCLK_DIV < 1) begin : g_bad_params
        $error("aud_codec_i2s_model: need SLOT_BITS >= DATA_W+1 and BCLK_DIV >= 1");
    end

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t            r_state;
    logic [DVW-1:0]    r_div;
    logic [CW-1:0]     r_bit_cnt;
    logic              r_bclk;
    logic              r_lrck;
    logic              r_adcdat;
    logic              r_adc_req;
    logic [DATA_W-1:0] r_adc_sh;
    logic [DATA_W-1:0] r_adc_r;
    logic [DATA_W-1:0] r_dac_sr;
    logic [DATA_W-1:0] r_dac_lhold;
    logic [DATA_W-1:0] r_dac_left;
    logic [DATA_W-1:0] r_dac_right;
    logic              r_dac_valid;

    logic              w_tick;
    logic              w_rise;
    logic              w_fall;
    logic [DATA_W-1:0] w_word;

    assign w_tick = (r_div == DMAX);
    assign w_rise = w_tick & ~r_bclk;
    assign w_fall = w_tick & r_bclk;
    assign w_word = {r_dac_sr[DATA_W-2:0], i_AUD_DACDAT};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_bclk      <= 1'b0;
            r_lrck      <= 1'b1;
            r_adcdat    <= 1'b0;
            r_adc_req   <= 1'b0;
            r_adc_sh    <= '0;
            r_adc_r     <= '0;
            r_dac_sr    <= '0;
            r_dac_lhold <= '0;
            r_dac_left  <= '0;
            r_dac_right <= '0;
            r_dac_valid <= 1'b0;
        end else begin
            r_adc_req   <= 1'b0;
            r_dac_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_en) begin
                        r_state   <= LEFT;
                        r_lrck    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_div     <= '0;
                        r_adc_sh  <= i_adc_left;
                        r_adc_r   <= i_adc_right;
                        r_adc_req <= 1'b1;
                    end
                end
                default: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick)
                        r_bclk <= ~r_bclk;
                    if (w_rise && r_bit_cnt != '0 && r_bit_cnt <= DW) begin
                        r_dac_sr <= w_word;
                        if (r_bit_cnt == DW && r_state == LEFT)
                            r_dac_lhold <= w_word;
                        else if (r_bit_cnt == DW) begin
                            r_dac_left  <= r_dac_lhold;
                            r_dac_right <= w_word;
                            r_dac_valid <= 1'b1;
                        end
                    end
                    if (w_fall && r_bit_cnt == LAST) begin
                        r_bit_cnt <= '0;
                        r_adcdat  <= 1'b0;
                        if (r_state == LEFT) begin
                            r_state  <= RIGHT;
                            r_lrck   <= 1'b1;
                            r_adc_sh <= r_adc_r;
                        end else if (i_en) begin
                            r_state   <= LEFT;
                            r_lrck    <= 1'b0;
                            r_adc_sh  <= i_adc_left;
                            r_adc_r   <= i_adc_right;
                            r_adc_req <= 1'b1;
                        end else
                            r_state <= IDLE;
                    end else if (w_fall) begin
                        // bit 0 of each slot is the I2S delay bit, data follows MSB first
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_adcdat  <= (r_bit_cnt < DW) ? r_adc_sh[DATA_W-1] : 1'b0;
                        if (r_bit_cnt < DW)
                            r_adc_sh <= {r_adc_sh[DATA_W-2:0], 1'b0};
                    end
                end
            endcase
        end
    end

    assign o_adc_req     = r_adc_req;
    assign o_AUD_BCLK    = r_bclk;
    assign o_AUD_ADCLRCK = r_lrck;
    assign o_AUD_DACLRCK = r_lrck;
    assign o_AUD_ADCDAT  = r_adcdat;
    assign o_dac_left    = r_dac_left;
    assign o_dac_right   = r_dac_right;
    assign o_dac_valid   = r_dac_valid;
endmodule

// File: tb/tb_aud_codec_i2s_model.sv
// tb_aud_codec_i2s_model: scoreboard bench with a frame-level I2S bus
// tracker that checks ADC words and drives/loops back the DAC stream.
module tb_aud_codec_i2s_model;
    typedef struct packed {logic [15:0] l; logic [15:0] r;} pair_t;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [15:0] adc_l = '0, adc_r = '0;
    logic        req, bclk, lrck, daclrck, adcdat, dacdat, valid;
    logic [15:0] dac_l, dac_r;

    int    n_vec = 0, n_err = 0, cyc = 0, last_req = -1;
    pair_t exp_adc[$], exp_dac[$];
    logic  lp = 1'b1, tx_bit;
    logic [15:0] tx_l = '0, tx_r = '0;

    logic        pb = 1'b0, pl = 1'b1, t_act = 1'b0, t_side = 1'b0, zbad = 1'b0, lbad = 1'b0, pv = 1'b0;
    int          t_bit = 0, s_start = 0;
    logic [15:0] rx = '0;

    aud_codec_i2s_model dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_adc_left(adc_l), .i_adc_right(adc_r), .o_adc_req(req),
        .o_AUD_BCLK(bclk), .o_AUD_ADCLRCK(lrck), .o_AUD_DACLRCK(daclrck),
        .o_AUD_ADCDAT(adcdat), .i_AUD_DACDAT(dacdat),
        .o_dac_left(dac_l), .o_dac_right(dac_r), .o_dac_valid(valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        tx_bit = 1'b0;
        if (t_act && t_bit >= 1 && t_bit <= 16)
            tx_bit = t_side ? tx_r[16-t_bit] : tx_l[16-t_bit];
    end
    assign dacdat = lp ? adcdat : tx_bit;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got nothing expected an event", nm);
    endtask

    // bus tracker: frame-level view of the I2S stream, checks each finished slot
    always @(negedge clk) begin
        if (rst) begin
            pb = 1'b0; pl = 1'b1; t_act = 1'b0; t_bit = 0;
        end else begin
            if (t_act && pb && !bclk) begin
                if (t_bit == 31) begin
                    if (exp_adc.size() == 0)
                        fail("adc_word_queue");
                    else begin
                        chk(t_side ? "adc_right" : "adc_left", rx, t_side ? exp_adc[0].r : exp_adc[0].l);
                        if (t_side) void'(exp_adc.pop_front());
                    end
                    chk("slot_len", cyc - s_start, 128);
                    chk("pad_bits_zero", zbad, 0);
                    chk("lrck_phase", lbad, 0);
                    rx = '0; zbad = 1'b0; lbad = 1'b0; t_bit = 0; s_start = cyc;
                    if (t_side && lrck) t_act = 1'b0;
                    else t_side = !t_side;
                end else
                    t_bit++;
            end else if (!t_act && pl && !lrck) begin
                t_act = 1'b1; t_side = 1'b0; t_bit = 0; rx = '0;
                zbad = 1'b0; lbad = 1'b0; s_start = cyc;
            end
            if (t_act && !pb && bclk) begin
                if (t_bit >= 1 && t_bit <= 16) rx = {rx[14:0], adcdat};
                else if (adcdat) zbad = 1'b1;
            end
            if (t_act && (lrck !== t_side || daclrck !== t_side)) lbad = 1'b1;
            pb = bclk;
            pl = lrck;
        end
    end

    always @(negedge clk) begin
        if (rst) pv = 1'b0;
        else begin
            if (valid) begin
                chk("valid_width", pv, 0);
                if (exp_dac.size() == 0)
                    fail("dac_word_queue");
                else begin
                    chk("dac_left", dac_l, exp_dac[0].l);
                    chk("dac_right", dac_r, exp_dac[0].r);
                    void'(exp_dac.pop_front());
                end
            end
            pv = valid;
        end
    end

    task automatic run_frame(input logic l, input pair_t tx, input pair_t nxt);
        int k = 0;
        do begin @(negedge clk); k++; end while (!req && k < 600);
        if (!req) begin fail("adc_req_timeout"); return; end
        if (last_req >= 0) chk("frame_period", cyc - last_req, 256);
        last_req = cyc;
        lp = l; tx_l = tx.l; tx_r = tx.r;
        exp_adc.push_back({adc_l, adc_r});
        exp_dac.push_back(l ? {adc_l, adc_r} : tx);
        adc_l = nxt.l; adc_r = nxt.r;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_adc.size() != 0 || exp_dac.size() != 0) && k < 1000) begin @(negedge clk); k++; end
        if (exp_adc.size() != 0 || exp_dac.size() != 0) fail("drain_timeout");
    endtask

    task automatic idle_check(input int n);
        int bad = 0, rq = 0, vl = 0;
        repeat (n) begin
            @(negedge clk);
            if (bclk !== 1'b0 || lrck !== 1'b1 || daclrck !== 1'b1 || adcdat !== 1'b0) bad++;
            if (req) rq++;
            if (valid) vl++;
        end
        chk("idle_bus", bad, 0);
        chk("idle_req", rq, 0);
        chk("idle_valid", vl, 0);
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {bclk, lrck, daclrck, adcdat, valid, req, dac_l, dac_r},
            {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk_reset("reset_state");
        rst = 1'b0;
        idle_check(1000);
        adc_l = 16'hA5C3; adc_r = 16'h0F0F; en = 1'b1;
        repeat (4) run_frame(1'b1, '0, {16'hA5C3, 16'h0F0F});
        run_frame(1'b0, {16'h8001, 16'h7FFE}, {16'h1234, 16'h5678});
        run_frame(1'b0, {16'hFFFF, 16'h0000}, pair_t'($urandom));
        repeat (8) run_frame(1'($urandom_range(0, 1)), pair_t'($urandom), pair_t'($urandom));
        run_frame(1'b1, '0, pair_t'($urandom));
        repeat (20) @(negedge clk);
        en = 1'b0;
        drain();
        idle_check(600);
        last_req = -1;
        en = 1'b1;
        repeat (2) run_frame(1'($urandom_range(0, 1)), pair_t'($urandom), pair_t'($urandom));
        run_frame(1'b0, pair_t'($urandom), pair_t'($urandom));
        k = 0;
        while (!(t_act && t_side && t_bit == 8) && k < 400) begin @(negedge clk); k++; end
        if (!(t_act && t_side && t_bit == 8)) fail("reach_right_bit8");
        #1 rst = 1'b1;
        #1 chk_reset("midframe_reset_async");
        exp_adc.delete(); exp_dac.delete(); last_req = -1;
        repeat (3) @(negedge clk);
        chk_reset("midframe_reset_held");
        rst = 1'b0;
        repeat (2) run_frame(1'($urandom_range(0, 1)), pair_t'($urandom), pair_t'($urandom));
        en = 1'b0;
        drain();
        idle_check(50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
